// File: rtl/axi_pkg.sv
// Shared AXI constants, bridge FSM state encoding and line-size helper for axi_line_bridge.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRdAddr = 3'd1;
  localparam logic [2:0] StRdData = 3'd2;
  localparam logic [2:0] StWr     = 3'd3;
  localparam logic [2:0] StWrResp = 3'd4;

  function automatic int unsigned line_bits(input int unsigned words);
    return words * 64;
  endfunction

endpackage

// File: rtl/axi_wline_buf.sv
// Writeback line buffer: loads a whole cache line, then presents it one 64-bit word per W beat.
module axi_wline_buf
  import axi_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic                               load,
  input  logic [line_bits(LINE_WORDS)-1:0]   line,
  input  logic                               advance,
  output logic [63:0]                        word,
  output logic                               last
);

  localparam int unsigned Bits = line_bits(LINE_WORDS);

  logic [Bits-1:0] line_q;
  logic [3:0]      cnt_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      line_q <= line;
      cnt_q  <= '0;
    end else if (advance) begin
      line_q <= {64'h0, line_q[Bits-1:64]};
      cnt_q  <= cnt_q + 4'd1;
    end
  end

  assign word = line_q[63:0];
  assign last = (cnt_q == 4'(LINE_WORDS - 1));

endmodule

// File: rtl/axi_line_bridge.sv
// Cache-line refill/writeback to AXI4 INCR burst master, one transaction outstanding.
// Define AXI_BRIDGE_RESP_CHECK_EN to enable sticky response/ID/burst-length error detection.
module axi_line_bridge
  import axi_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter logic [3:0]  AXI_ID     = 4'h0
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic                             rd_req_valid,
  output logic                             rd_req_ready,
  input  logic [31:0]                      rd_req_addr,
  output logic                             rd_data_valid,
  output logic [63:0]                      rd_data,
  output logic                             rd_data_last,
  input  logic                             wr_req_valid,
  output logic                             wr_req_ready,
  input  logic [31:0]                      wr_req_addr,
  input  logic [line_bits(LINE_WORDS)-1:0] wr_req_line,
  output logic                             busy,
  output logic                             err,
  output logic [31:0]                      araddr,
  output logic [3:0]                       arid,
  output logic [7:0]                       arlen,
  output logic [2:0]                       arsize,
  output logic [1:0]                       arburst,
  output logic [1:0]                       arlock,
  output logic [3:0]                       arcache,
  output logic [2:0]                       arprot,
  output logic                             arvalid,
  input  logic                             arready,
  input  logic [3:0]                       rid,
  input  logic [63:0]                      rdata,
  input  logic [1:0]                       rresp,
  input  logic                             rlast,
  input  logic                             rvalid,
  output logic                             rready,
  output logic [31:0]                      awaddr,
  output logic [3:0]                       awid,
  output logic [7:0]                       awlen,
  output logic [2:0]                       awsize,
  output logic [1:0]                       awburst,
  output logic [1:0]                       awlock,
  output logic [3:0]                       awcache,
  output logic [2:0]                       awprot,
  output logic                             awvalid,
  input  logic                             awready,
  output logic [3:0]                       wid,
  output logic [63:0]                      wdata,
  output logic [7:0]                       wstrb,
  output logic                             wlast,
  output logic                             wvalid,
  input  logic                             wready,
  input  logic [3:0]                       bid,
  input  logic [1:0]                       bresp,
  input  logic                             bvalid,
  output logic                             bready
);

  localparam logic [31:0] AddrMask = ~((32'd1 << ($clog2(LINE_WORDS) + 3)) - 32'd1);
  localparam logic [3:0]  LastBeat = 4'(LINE_WORDS - 1);
  localparam logic [7:0]  BurstLen = 8'(LINE_WORDS - 1);

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  rd_cnt_q, rd_cnt_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        aw_hs, w_hs, buf_load, buf_last, overrun;
  logic [63:0] buf_word;

  axi_wline_buf #(
    .LINE_WORDS (LINE_WORDS)
  ) u_wline_buf (
    .aclk    (aclk),
    .aresetn (aresetn),
    .load    (buf_load),
    .line    (wr_req_line),
    .advance (w_hs),
    .word    (buf_word),
    .last    (buf_last)
  );

  assign busy         = (state_q != StIdle);
  assign wr_req_ready = (state_q == StIdle);
  assign rd_req_ready = (state_q == StIdle) && !wr_req_valid;
  assign buf_load     = (state_q == StIdle) && wr_req_valid;

  assign arvalid = (state_q == StRdAddr);
  assign araddr  = addr_q;
  assign arid    = AXI_ID;
  assign arlen   = arvalid ? BurstLen : 8'h0;
  assign arsize  = AXI_SIZE_8B;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'h0;
  assign arprot  = 3'h0;

  assign rready        = (state_q == StRdData);
  assign rd_data_valid = rready && rvalid;
  assign rd_data       = rdata;
  assign rd_data_last  = rd_data_valid && rlast;

  // AW and W are tracked separately so either channel may complete first.
  assign awvalid = (state_q == StWr) && !aw_done_q;
  assign awaddr  = addr_q;
  assign awid    = AXI_ID;
  assign awlen   = awvalid ? BurstLen : 8'h0;
  assign awsize  = AXI_SIZE_8B;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'h0;
  assign awprot  = 3'h0;
  assign aw_hs   = awvalid && awready;

  assign wvalid = (state_q == StWr) && !w_done_q;
  assign wid    = AXI_ID;
  assign wdata  = buf_word;
  assign wstrb  = 8'hFF;
  assign wlast  = buf_last;
  assign w_hs   = wvalid && wready;

  assign bready = (state_q == StWrResp);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rd_cnt_d  = rd_cnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      StIdle: begin
        if (wr_req_valid) begin
          addr_d    = wr_req_addr & AddrMask;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StWr;
        end else if (rd_req_valid) begin
          addr_d   = rd_req_addr & AddrMask;
          rd_cnt_d = 4'd0;
          state_d  = StRdAddr;
        end
      end
      StRdAddr: if (arready) state_d = StRdData;
      StRdData: begin
        if (rvalid) begin
          rd_cnt_d = rd_cnt_q + 4'd1;
          if (rlast || overrun) state_d = StIdle;
        end
      end
      StWr: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs && buf_last) w_done_d = 1'b1;
        if (aw_done_d && w_done_d) state_d = StWrResp;
      end
      StWrResp: if (bvalid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      rd_cnt_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_cnt_q  <= rd_cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

`ifdef AXI_BRIDGE_RESP_CHECK_EN
  logic err_q, r_bad, b_bad;

  // A full line of beats without rlast means the slave is overrunning the burst; bail out.
  assign overrun = (state_q == StRdData) && rvalid && !rlast && (rd_cnt_q == LastBeat);
  assign r_bad   = (state_q == StRdData) && rvalid &&
                   ((rresp != AXI_RESP_OKAY) || (rid != AXI_ID) ||
                    (rlast && (rd_cnt_q != LastBeat)));
  assign b_bad   = (state_q == StWrResp) && bvalid &&
                   ((bresp != AXI_RESP_OKAY) || (bid != AXI_ID));

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      err_q <= 1'b0;
    end else if (r_bad || b_bad || overrun) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_resp;

  assign overrun     = 1'b0;
  assign err         = 1'b0;
  assign unused_resp = ^{rid, rresp, bid, bresp, rd_cnt_q, LastBeat};
`endif

endmodule

// File: tb/tb_axi_line_bridge.sv
// Self-checking bench for axi_line_bridge: randomized refills/writebacks against a line-level model.
module tb_axi_line_bridge;

  localparam int         LW   = 4;
  localparam logic [3:0] TbId = 4'h3;
`ifdef AXI_BRIDGE_RESP_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  logic aclk = 1'b0;
  logic aresetn;
  logic rd_req_valid, rd_req_ready, rd_data_valid, rd_data_last;
  logic [31:0] rd_req_addr, wr_req_addr;
  logic [63:0] rd_data;
  logic wr_req_valid, wr_req_ready, busy, err;
  logic [LW*64-1:0] wr_req_line;
  logic [31:0] araddr, awaddr;
  logic [3:0] arid, arcache, awid, awcache, rid, wid, bid;
  logic [7:0] arlen, awlen, wstrb;
  logic [2:0] arsize, arprot, awsize, awprot;
  logic [1:0] arburst, arlock, awburst, awlock, rresp, bresp;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic [63:0] rdata, wdata;
  logic wlast, wvalid, wready, bvalid, bready;

  int checks = 0;
  int failures = 0;
  bit err_model = 1'b0;

  always #5 aclk = ~aclk;

  axi_line_bridge #(
    .LINE_WORDS (LW),
    .AXI_ID     (TbId)
  ) dut (
    .aclk (aclk), .aresetn (aresetn),
    .rd_req_valid (rd_req_valid), .rd_req_ready (rd_req_ready), .rd_req_addr (rd_req_addr),
    .rd_data_valid (rd_data_valid), .rd_data (rd_data), .rd_data_last (rd_data_last),
    .wr_req_valid (wr_req_valid), .wr_req_ready (wr_req_ready), .wr_req_addr (wr_req_addr),
    .wr_req_line (wr_req_line), .busy (busy), .err (err),
    .araddr (araddr), .arid (arid), .arlen (arlen), .arsize (arsize), .arburst (arburst),
    .arlock (arlock), .arcache (arcache), .arprot (arprot), .arvalid (arvalid),
    .arready (arready),
    .rid (rid), .rdata (rdata), .rresp (rresp), .rlast (rlast), .rvalid (rvalid),
    .rready (rready),
    .awaddr (awaddr), .awid (awid), .awlen (awlen), .awsize (awsize), .awburst (awburst),
    .awlock (awlock), .awcache (awcache), .awprot (awprot), .awvalid (awvalid),
    .awready (awready),
    .wid (wid), .wdata (wdata), .wstrb (wstrb), .wlast (wlast), .wvalid (wvalid),
    .wready (wready),
    .bid (bid), .bresp (bresp), .bvalid (bvalid), .bready (bready)
  );

  function automatic logic [31:0] line_base(input logic [31:0] a);
    return a - (a % 32'(LW * 8));
  endfunction

  task automatic idle_inputs();
    rd_req_valid = 0; rd_req_addr = '0; wr_req_valid = 0; wr_req_addr = '0;
    wr_req_line = '0; arready = 0; awready = 0; wready = 0; bvalid = 0;
    rid = TbId; rdata = '0; rresp = '0; rlast = 0; rvalid = 0; bid = TbId; bresp = '0;
  endtask

  task automatic test_reset();
    aresetn = 0;
    idle_inputs();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if ({busy, err, arvalid, awvalid, wvalid, rready, bready, rd_data_valid} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=00000000",
               {busy, err, arvalid, awvalid, wvalid, rready, bready, rd_data_valid});
    end
    checks++;
    if ({araddr, awaddr, wdata, arlen, awlen} !== '0) begin
      failures++;
      $display("FAIL reset_payload got=%h want=0", {araddr, awaddr, wdata, arlen, awlen});
    end
    aresetn = 1;
    err_model = 1'b0;
    @(posedge aclk); #1;
    @(negedge aclk);
    checks++;
    if ({wr_req_ready, rd_req_ready, busy} !== 3'b110) begin
      failures++;
      $display("FAIL reset_ready got=%b want=110", {wr_req_ready, rd_req_ready, busy});
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_refill(input logic [31:0] addr, input int ar_delay, input bit gaps,
                             input bit fixed, input bit skip_req);
    logic [63:0] beats[LW];
    logic [31:0] base;
    int cyc, idx;
    bit hs;
    base = line_base(addr);
    for (int i = 0; i < LW; i++) beats[i] = fixed ? 64'(17 * (i + 1)) : {$urandom, $urandom};
    if (!skip_req) begin
      rd_req_valid = 1; rd_req_addr = addr;
      @(negedge aclk);
      checks++;
      if (rd_req_ready !== 1'b1) begin
        failures++;
        $display("FAIL rd_req_ready got=%b want=1", rd_req_ready);
      end
      @(posedge aclk); #1;
    end
    rd_req_valid = 0; rd_req_addr = $urandom;
    cyc = 0; hs = 0;
    while (!hs && cyc < 50) begin
      arready = (cyc >= ar_delay);
      @(negedge aclk);
      checks++;
      if ({arvalid, araddr, arlen, arsize, arburst, arid, arlock, arcache, arprot, busy} !==
          {1'b1, base, 8'(LW - 1), 3'd3, 2'b01, TbId, 2'b00, 4'h0, 3'h0, 1'b1}) begin
        failures++;
        $display("FAIL ar_chan cyc=%0d got v=%b a=%h len=%h sz=%h bu=%b id=%h want v=1 a=%h len=%h",
                 cyc, arvalid, araddr, arlen, arsize, arburst, arid, base, 8'(LW - 1));
      end
      hs = (arvalid === 1'b1) && arready;
      @(posedge aclk); #1;
      cyc++;
    end
    arready = 0;
    checks++;
    if (!hs) begin
      failures++;
      $display("FAIL ar_timeout got=no_handshake want=handshake");
    end
    idx = 0; cyc = 0;
    while (idx < LW && cyc < 100) begin
      rvalid = !gaps || ($urandom_range(0, 2) != 0);
      rdata  = rvalid ? beats[idx] : {$urandom, $urandom};
      rlast  = rvalid && (idx == LW - 1);
      rresp  = 2'b00; rid = TbId;
      @(negedge aclk);
      checks++;
      if (rvalid) begin
        if ({rready, rd_data_valid, rd_data, rd_data_last} !==
            {1'b1, 1'b1, beats[idx], idx == LW - 1}) begin
          failures++;
          $display("FAIL r_beat%0d got rdy=%b v=%b d=%h l=%b want rdy=1 v=1 d=%h l=%b", idx,
                   rready, rd_data_valid, rd_data, rd_data_last, beats[idx], idx == LW - 1);
        end
        idx++;
      end else if ({rready, rd_data_valid, arvalid} !== 3'b100) begin
        failures++;
        $display("FAIL r_gap got=%b want=100", {rready, rd_data_valid, arvalid});
      end
      @(posedge aclk); #1;
      cyc++;
    end
    rvalid = 0; rlast = 0;
    checks++;
    if (idx != LW) begin
      failures++;
      $display("FAIL r_timeout got=%0d want=%0d", idx, LW);
    end
    @(negedge aclk);
    checks++;
    if ({busy, rd_data_valid, arvalid, rd_req_ready, err} !== {3'b000, 1'b1, err_model}) begin
      failures++;
      $display("FAIL rd_end got=%b want=%b", {busy, rd_data_valid, arvalid, rd_req_ready, err},
               {3'b000, 1'b1, err_model});
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_writeback(input logic [31:0] addr, input int aw_delay, input int w_delay,
                                input bit gaps, input logic [1:0] bresp_v, input bit fixed,
                                input bit hold_rd);
    logic [63:0] words[LW];
    logic [63:0] got[$];
    logic [63:0] g;
    logic [LW*64-1:0] line;
    logic [31:0] base;
    int aw_cnt, cyc;
    base = line_base(addr);
    for (int i = 0; i < LW; i++) begin
      words[i] = fixed ? 64'(i + 1) : {$urandom, $urandom};
      line[i*64 +: 64] = words[i];
    end
    wr_req_valid = 1; wr_req_addr = addr; wr_req_line = line;
    @(negedge aclk);
    checks++;
    if (wr_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL wr_req_ready got=%b want=1", wr_req_ready);
    end
    if (hold_rd) begin
      checks++;
      if (rd_req_ready !== 1'b0) begin
        failures++;
        $display("FAIL prio_rd_ready got=%b want=0", rd_req_ready);
      end
    end
    @(posedge aclk); #1;
    wr_req_valid = 0; wr_req_addr = $urandom; wr_req_line = '0;
    aw_cnt = 0; cyc = 0;
    while ((aw_cnt == 0 || got.size() < LW) && cyc < 100) begin
      awready = (cyc >= aw_delay) && (!gaps || ($urandom_range(0, 2) != 0));
      wready  = (cyc >= w_delay) && (!gaps || ($urandom_range(0, 2) != 0));
      @(negedge aclk);
      if (cyc == 0) begin
        checks++;
        if ({awvalid, wvalid} !== 2'b11) begin
          failures++;
          $display("FAIL wr_entry got=%b want=11", {awvalid, wvalid});
        end
      end
      if (awvalid === 1'b1) begin
        checks++;
        if ({awaddr, awlen, awsize, awburst, awid} !== {base, 8'(LW - 1), 3'd3, 2'b01, TbId}) begin
          failures++;
          $display("FAIL aw_chan got a=%h len=%h sz=%h bu=%b id=%h want a=%h len=%h", awaddr,
                   awlen, awsize, awburst, awid, base, 8'(LW - 1));
        end
      end
      if (aw_cnt > 0) begin
        checks++;
        if (awvalid !== 1'b0) begin
          failures++;
          $display("FAIL aw_dup got=%b want=0", awvalid);
        end
      end
      if (awvalid === 1'b1 && awready) aw_cnt++;
      if (wvalid === 1'b1 && wready) begin
        checks++;
        if ({wlast, wstrb, wid} !== {got.size() == LW - 1, 8'hFF, TbId}) begin
          failures++;
          $display("FAIL w_ctrl beat=%0d got l=%b s=%h id=%h want l=%b s=ff", got.size(), wlast,
                   wstrb, wid, got.size() == LW - 1);
        end
        got.push_back(wdata);
      end
      if (hold_rd) begin
        checks++;
        if (rd_req_ready !== 1'b0) begin
          failures++;
          $display("FAIL prio_hold got=%b want=0", rd_req_ready);
        end
      end
      @(posedge aclk); #1;
      cyc++;
    end
    awready = 0; wready = 1;
    checks++;
    if (aw_cnt != 1) begin
      failures++;
      $display("FAIL aw_count got=%0d want=1", aw_cnt);
    end
    for (int i = 0; i < LW; i++) begin
      g = (i < got.size()) ? got[i] : 64'hDEAD_DEAD_DEAD_DEAD;
      checks++;
      if (g !== words[i]) begin
        failures++;
        $display("FAIL w_data%0d got=%h want=%h", i, g, words[i]);
      end
    end
    bvalid = 1; bresp = bresp_v; bid = TbId;
    @(negedge aclk);
    checks++;
    if ({bready, awvalid, wvalid, busy} !== 4'b1001) begin
      failures++;
      $display("FAIL wr_resp got=%b want=1001", {bready, awvalid, wvalid, busy});
    end
    @(posedge aclk); #1;
    bvalid = 0; bresp = 2'b00; wready = 0;
    err_model = err_model | (CheckEn && (bresp_v != 2'b00));
    @(negedge aclk);
    checks++;
    if ({busy, err} !== {1'b0, err_model}) begin
      failures++;
      $display("FAIL wr_end got=%b want=%b", {busy, err}, {1'b0, err_model});
    end
    if (hold_rd) begin
      checks++;
      if (rd_req_ready !== 1'b1) begin
        failures++;
        $display("FAIL prio_rd_after got=%b want=1", rd_req_ready);
      end
    end
    @(posedge aclk); #1;
    if (hold_rd) rd_req_valid = 0;
  endtask

  task automatic test_priority();
    logic [31:0] ra;
    ra = $urandom;
    rd_req_valid = 1; rd_req_addr = ra;
    test_writeback($urandom, 1, 0, 1, 2'b00, 0, 1);
    rd_req_addr = ra;
    test_refill(ra, 0, 1, 0, 1);
  endtask

  task automatic test_reset_mid();
    rd_req_valid = 1; rd_req_addr = $urandom;
    @(posedge aclk); #1;
    rd_req_valid = 0; arready = 1;
    @(negedge aclk);
    checks++;
    if (arvalid !== 1'b1) begin
      failures++;
      $display("FAIL rm_arvalid got=%b want=1", arvalid);
    end
    @(posedge aclk); #1;
    arready = 0; rvalid = 1; rdata = {$urandom, $urandom}; rlast = 0; rid = TbId; rresp = 0;
    @(posedge aclk); #1;
    rdata = {$urandom, $urandom};
    aresetn = 0;
    @(negedge aclk);
    checks++;
    if (rd_data_valid !== 1'b1) begin
      failures++;
      $display("FAIL rm_beat2 got=%b want=1", rd_data_valid);
    end
    @(posedge aclk); #1;
    rvalid = 0;
    @(negedge aclk);
    checks++;
    if ({arvalid, rready, busy, rd_data_valid, err} !== 5'b00000) begin
      failures++;
      $display("FAIL rm_after got=%b want=00000", {arvalid, rready, busy, rd_data_valid, err});
    end
    aresetn = 1;
    err_model = 1'b0;
    @(posedge aclk); #1;
  endtask

  task automatic test_resp_err();
    test_writeback($urandom, 0, 0, 0, 2'b10, 0, 0);
    test_refill($urandom, 0, 0, 0, 0);
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_refill(32'h8000_0013, 0, 0, 1, 0);
    test_writeback(32'h8000_0040, 0, 2, 0, 2'b00, 1, 0);
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) test_refill($urandom, $urandom_range(0, 3), 1, 0, 0);
      else test_writeback($urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1, 2'b00, 0, 0);
    end
    test_priority();
    test_reset_mid();
    test_refill($urandom, 0, 0, 0, 0);
    test_refill($urandom, 5, 0, 0, 0);
    test_writeback($urandom, 5, 0, 0, 2'b00, 0, 0);
    test_resp_err();
    test_reset();
    test_refill($urandom, 1, 1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
